// File: rtl/pmc_ctrl_if.sv
// Byte-stream link carrying the metrics frame from pmc_ctrl to its sink.
`timescale 1ns/1ps
interface pmc_ctrl_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       dump_busy;

   modport master (output tx_data, output tx_valid, output dump_busy, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input dump_busy, output tx_ready);
endinterface

// File: rtl/pmc_ctrl.sv
// PMC measurement-window controller plus a 16-byte metrics frame sender.
// The two FSMs run independently; all outputs are registered.
`timescale 1ns/1ps
module pmc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic        cmd_stop,
   input  logic        cmd_dump,
   input  logic [31:0] stall_count,
   input  logic [15:0] cpi_q78,
   input  logic [31:0] arith_count,
   input  logic [31:0] mem_count,
   output logic        pmc_clr,
   output logic        pmc_en,
   output logic        counting,
   pmc_ctrl_if.master  tx
);

   typedef enum logic [2:0] {IDLE, CLR, ARM, RUN, DISARM} ctl_state_t;
   typedef enum logic       {S_IDLE, S_SEND} snd_state_t;

   typedef struct packed {
      logic [31:0] mem;
      logic [31:0] arith;
      logic [15:0] cpi;
      logic [31:0] stall;
   } snap_t;

   ctl_state_t ctl_state;
   snd_state_t snd_state;
   snap_t      snap;
   logic [3:0] idx;

   // Byte idx of the frame built from a snapshot; byte 15 is the XOR of bytes 0..14.
   function automatic logic [7:0] frame_byte(input snap_t s, input logic [3:0] i);
      logic [119:0] body;
      logic [7:0]   sum;
      body = {s.mem, s.arith, s.cpi, s.stall, 8'hA5};
      sum  = 8'h00;
      for (int k = 0; k < 15; k++) begin
         sum = sum ^ body[8*k +: 8];
      end
      if (i == 4'd15) return sum;
      return body[{i, 3'b000} +: 8];
   endfunction

   // Control FSM; outputs are set on the edge that enters the state they belong to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         ctl_state <= IDLE;
         pmc_clr   <= 1'b1;
         pmc_en    <= 1'b0;
         counting  <= 1'b0;
      end else begin
         pmc_clr <= 1'b0;
         pmc_en  <= 1'b0;
         case (ctl_state)
            IDLE: begin
               if (cmd_start && !cmd_stop) begin
                  ctl_state <= CLR;
                  pmc_clr   <= 1'b1;
               end
            end
            CLR: begin
               ctl_state <= ARM;
               pmc_en    <= 1'b1;
            end
            ARM: begin
               ctl_state <= RUN;
               counting  <= 1'b1;
            end
            RUN: begin
               if (cmd_stop) begin
                  ctl_state <= DISARM;
                  pmc_en    <= 1'b1;
               end
            end
            DISARM: begin
               ctl_state <= IDLE;
               counting  <= 1'b0;
            end
            default: begin
               ctl_state <= IDLE;
               counting  <= 1'b0;
            end
         endcase
      end
   end

   // Sender FSM; tx_data is loaded one byte ahead so it is valid with tx_valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the snapshot is cleared on reset so a stale frame can never leak after an abort.
         snd_state   <= S_IDLE;
         snap        <= '0;
         idx         <= 4'd0;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= 8'h00;
      end else begin
         case (snd_state)
            S_IDLE: begin
               if (cmd_dump) begin
                  snap        <= '{mem: mem_count, arith: arith_count,
                                   cpi: cpi_q78, stall: stall_count};
                  snd_state   <= S_SEND;
                  idx         <= 4'd0;
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= 8'hA5;
               end
            end
            S_SEND: begin
               if (tx.tx_ready) begin
                  if (idx == 4'd15) begin
                     snd_state   <= S_IDLE;
                     idx         <= 4'd0;
                     tx.tx_valid <= 1'b0;
                     tx.tx_data  <= 8'h00;
                  end else begin
                     idx        <= idx + 4'd1;
                     tx.tx_data <= frame_byte(snap, idx + 4'd1);
                  end
               end
            end
            default: begin
               snd_state   <= S_IDLE;
               tx.tx_valid <= 1'b0;
               tx.tx_data  <= 8'h00;
            end
         endcase
      end
   end

   assign tx.dump_busy = (snd_state == S_SEND);

endmodule

// File: tb/tb_pmc_ctrl.sv
// Self-checking bench for pmc_ctrl: cycle-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_pmc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_dump = 1'b0;
   logic [31:0] stall_count = '0, arith_count = '0, mem_count = '0;
   logic [15:0] cpi_q78 = '0;
   logic        pmc_clr, pmc_en, counting;

   pmc_ctrl_if tx_if ();

   pmc_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_start   (cmd_start),
      .cmd_stop    (cmd_stop),
      .cmd_dump    (cmd_dump),
      .stall_count (stall_count),
      .cpi_q78     (cpi_q78),
      .arith_count (arith_count),
      .mem_count   (mem_count),
      .pmc_clr     (pmc_clr),
      .pmc_en      (pmc_en),
      .counting    (counting),
      .tx          (tx_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: window age since an accepted start, and a queue of frame bytes still owed.
   int         win_age  = -1;
   bit         disarm   = 1'b0;
   bit         m_clr    = 1'b1;
   bit         model_on = 1'b0;
   logic [7:0] q[$];

   always @(posedge clk) begin
      bit nd;
      logic [7:0] b[16];
      if (!reset) begin
         win_age  = -1;
         disarm   = 1'b0;
         m_clr    = 1'b1;
         q.delete();
         model_on = 1'b1;
      end else begin
         if (q.size() > 0) begin
            if (tx_if.tx_ready) void'(q.pop_front());
         end else if (cmd_dump) begin
            b[0] = 8'hA5;
            for (int i = 0; i < 4; i++) begin
               b[1 + i]  = 8'((stall_count >> (8 * i)) & 32'hFF);
               b[7 + i]  = 8'((arith_count >> (8 * i)) & 32'hFF);
               b[11 + i] = 8'((mem_count   >> (8 * i)) & 32'hFF);
            end
            b[5]  = cpi_q78[7:0];
            b[6]  = cpi_q78[15:8];
            b[15] = 8'h00;
            for (int i = 0; i < 15; i++) b[15] = b[15] ^ b[i];
            for (int i = 0; i < 16; i++) q.push_back(b[i]);
         end
         nd = 1'b0;
         if (win_age < 0) begin
            if (!disarm && cmd_start && !cmd_stop) win_age = 1;
         end else if (win_age < 3) begin
            win_age++;
         end else if (cmd_stop) begin
            win_age = -1;
            nd      = 1'b1;
         end
         disarm = nd;
         m_clr  = (win_age == 1);
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("m_pmc_clr",   32'(pmc_clr),   32'(m_clr));
         check("m_pmc_en",    32'(pmc_en),    32'((win_age == 2) || disarm));
         check("m_counting",  32'(counting),  32'((win_age >= 3) || disarm));
         check("m_tx_valid",  32'(tx_if.tx_valid),  32'(q.size() > 0));
         check("m_dump_busy", 32'(tx_if.dump_busy), 32'(q.size() > 0));
         check("m_tx_data",   32'(tx_if.tx_data),   32'((q.size() > 0) ? q[0] : 8'h00));
      end
   end

   task automatic nclk(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ref_inputs();
      stall_count = 32'h11223344;
      cpi_q78     = 16'h0280;
      arith_count = 32'h0000000A;
      mem_count   = 32'h01000002;
   endtask

   logic [7:0] lit [16];

   initial begin
      lit = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h80, 8'h02, 8'h0A,
              8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h6A};
      tx_if.tx_ready = 1'b1;
      nclk(3);
      check("rst_pmc_clr",  32'(pmc_clr), 32'd1);
      check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
      check("rst_tx_data",  32'(tx_if.tx_data), 32'd0);

      // Start window right at reset release
      reset = 1'b1; cmd_start = 1'b1;
      nclk(); cmd_start = 1'b0;
      check("start_clr_c1", 32'(pmc_clr), 32'd1);
      nclk();
      check("start_en_c2",  32'(pmc_en), 32'd1);
      check("start_clr_c2", 32'(pmc_clr), 32'd0);
      nclk();
      check("start_cnt_c3", 32'(counting), 32'd1);
      check("start_en_c3",  32'(pmc_en), 32'd0);
      nclk(4);

      // Stop window
      cmd_stop = 1'b1;
      nclk(); cmd_stop = 1'b0;
      check("stop_en_n1",  32'(pmc_en), 32'd1);
      check("stop_cnt_n1", 32'(counting), 32'd1);
      nclk();
      check("stop_cnt_n2", 32'(counting), 32'd0);
      check("stop_en_n2",  32'(pmc_en), 32'd0);

      // Simultaneous start and stop in IDLE is ignored
      nclk(2);
      cmd_start = 1'b1; cmd_stop = 1'b1;
      nclk(); cmd_start = 1'b0; cmd_stop = 1'b0;
      check("coll_clr", 32'(pmc_clr), 32'd0);
      nclk();
      check("coll_en",  32'(pmc_en), 32'd0);

      // Reference frame, with a second dump injected mid-frame
      set_ref_inputs(); cmd_dump = 1'b1;
      nclk(); cmd_dump = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("frame_valid_%0d", k), 32'(tx_if.tx_valid), 32'd1);
         check($sformatf("frame_byte_%0d", k),  32'(tx_if.tx_data),  32'(lit[k]));
         cmd_dump = (k == 5);
         if (k == 6) begin
            stall_count = 32'hDEADBEEF;
            mem_count   = 32'hCAFEF00D;
         end
         nclk();
      end
      cmd_dump = 1'b0;
      check("frame_end_valid", 32'(tx_if.tx_valid), 32'd0);
      check("frame_end_data",  32'(tx_if.tx_data),  32'd0);
      nclk();
      check("no_second_frame", 32'(tx_if.tx_valid), 32'd0);

      // Backpressure at byte 3
      set_ref_inputs(); cmd_dump = 1'b1;
      nclk(); cmd_dump = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("bp_byte_%0d", k), 32'(tx_if.tx_data), 32'(lit[k]));
         if (k == 3) begin
            tx_if.tx_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
               nclk();
               check("bp_hold_data",  32'(tx_if.tx_data),  32'h22);
               check("bp_hold_valid", 32'(tx_if.tx_valid), 32'd1);
            end
            tx_if.tx_ready = 1'b1;
         end
         nclk();
      end
      check("bp_end_valid", 32'(tx_if.tx_valid), 32'd0);

      // Reset at frame byte 7 while counting
      cmd_start = 1'b1;
      nclk(); cmd_start = 1'b0;
      nclk(3);
      cmd_dump = 1'b1;
      nclk(); cmd_dump = 1'b0;
      nclk(7);
      check("pre_rst_byte7", 32'(tx_if.tx_data), 32'(lit[7]));
      check("pre_rst_cnt",   32'(counting), 32'd1);
      reset = 1'b0;
      nclk();
      check("abort_valid", 32'(tx_if.tx_valid), 32'd0);
      check("abort_cnt",   32'(counting), 32'd0);
      check("abort_clr",   32'(pmc_clr), 32'd1);
      check("abort_en",    32'(pmc_en), 32'd0);
      reset = 1'b1;
      nclk();
      check("abort_no_disarm", 32'(pmc_en), 32'd0);
      check("abort_idle_clr",  32'(pmc_clr), 32'd0);

      // Randomized traffic checked every cycle by the model
      for (int c = 0; c < 4000; c++) begin
         cmd_start      = ($urandom_range(0, 7) == 0);
         cmd_stop       = ($urandom_range(0, 7) == 0);
         cmd_dump       = ($urandom_range(0, 9) == 0);
         tx_if.tx_ready = ($urandom_range(0, 3) != 0);
         reset          = ($urandom_range(0, 499) != 0);
         stall_count    = $urandom();
         cpi_q78        = 16'($urandom());
         arith_count    = $urandom();
         mem_count      = $urandom();
         nclk();
      end

      // Drain any frame in flight, bounded
      cmd_start = 1'b0; cmd_stop = 1'b0; cmd_dump = 1'b0;
      reset = 1'b1; tx_if.tx_ready = 1'b1;
      for (int c = 0; c < 64 && q.size() > 0; c++) nclk();
      nclk();
      check("drain_busy", 32'(tx_if.dump_busy), 32'd0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
